fir_pipe_param: RTL

Parametrised, pipelined direct-form FIR filter. It is the successor of the single-stage FIR in the signal path and sits between the sample source and the output formatter.
- Adds valid/ready handshakes, an addressed coefficient load with a drain phase, and a registered 3-stage datapath.
- Adds configurable output scaling with saturation and a per-sample saturation flag.

---
 rtl/fir_pkg.sv | 55 +++++
 rtl/fir_sat_stage.sv | 71 +++++++
 rtl/fir_pipe_param.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the pipelined FIR filter.
//   - fir_state_t : control FSM state encoding (INIT, RUN, DRAIN, LOAD)
//   - clog2       : ceiling log2, usable in parameter expressions
//   - sat_shift   : arithmetic right shift followed by saturation to a
//                   signed y_w-bit range, reporting whether clipping occurred
// Values travel through sat_shift at SAT_W bits, so any accumulator up to
// SAT_W bits can be handled without a parameterised function.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_LOAD  = 2'd3
  } fir_state_t;

  localparam int SAT_W = 64;

  typedef struct packed {
    logic                    sat;
    logic signed [SAT_W-1:0] val;
  } sat_res_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Shift right arithmetically, then clip into [-2^(y_w-1), 2^(y_w-1)-1].
  function automatic sat_res_t sat_shift(input logic signed [SAT_W-1:0] acc,
                                         input int shift,
                                         input int y_w);
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                r;
    shifted = acc >>> shift;
    hi      = (64'sd1 <<< (y_w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (y_w - 1));
    if (shifted > hi) begin
      r.sat = 1'b1;
      r.val = hi;
    end else if (shifted < lo) begin
      r.sat = 1'b1;
      r.val = lo;
    end else begin
      r.sat = 1'b0;
      r.val = shifted;
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_sat_stage.sv
// fir_sat_stage: third pipeline stage of the FIR. Registers the scaled and
// saturated accumulator together with its valid and saturation flag.
//
// Build option:
//   FIR_ROUND_EN - when defined and OUT_SHIFT > 0, 2^(OUT_SHIFT-1) is added
//                  before the shift (round half up). Otherwise the shift
//                  truncates. Latency is identical either way.
//
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   en         - advance enable; low while the output is stalled
//   in_valid   - stage-2 valid
//   acc        - stage-2 full precision sum (signed, ACC_W)
//   m_valid    - output valid
//   m_data     - scaled, saturated output (signed, Y_W)
//   m_sat      - m_data was clipped
module fir_sat_stage
  import fir_pkg::*;
#(
  parameter int ACC_W     = 18,
  parameter int Y_W       = 14,
  parameter int OUT_SHIFT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    in_valid,
  input  logic signed [ACC_W-1:0] acc,
  output logic                    m_valid,
  output logic signed [Y_W-1:0]   m_data,
  output logic                    m_sat
);

`ifdef FIR_ROUND_EN
  localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;
  localparam logic signed [SAT_W-1:0] RND_ADD =
    (OUT_SHIFT > 0) ? (64'sd1 <<< RND_POS) : 64'sd0;
`endif

  logic signed [SAT_W-1:0] acc_ext;
  sat_res_t                res;
  logic                    unused_hi;

  always_comb begin
    acc_ext = SAT_W'(acc);
`ifdef FIR_ROUND_EN
    acc_ext = acc_ext + RND_ADD;
`endif
    res = sat_shift(acc_ext, OUT_SHIFT, Y_W);
  end

  // After saturation the upper bits are pure sign extension.
  assign unused_hi = ^res.val[SAT_W-1:Y_W];

  // Data only moves for real samples so m_data/m_sat stay on the last
  // delivered value across bubbles and stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_sat   <= 1'b0;
    end else if (en) begin
      m_valid <= in_valid;
      if (in_valid) begin
        m_data <= res.val[Y_W-1:0];
        m_sat  <= res.sat;
      end
    end
  end

endmodule

// File: rtl/fir_pipe_param.sv
// fir_pipe_param: parametrised, pipelined direct-form FIR filter
//   y[n] = sum_{k=0}^{NTAPS-1} h[k] * x[n-k]
// with valid/ready streaming on input and output, an addressed coefficient
// reload that first drains the pipeline, and output scaling with saturation.
//
// Pipeline (3 registers after the accepting edge):
//   stage 1 - NTAPS products of the window {s_data, delay line}
//   stage 2 - full precision ACC_W sum
//   stage 3 - shift/round/saturate (fir_sat_stage)
// The whole pipeline and the delay line hold while m_valid && !m_ready.
//
// Build option: FIR_ROUND_EN enables round-half-up before the output shift
// (see fir_sat_stage).
//
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   s_valid/s_data       - input sample x[n] (signed, X_W)
//   s_ready              - sample accepted this cycle when s_valid is high
//   coef_start           - one-cycle reload request (honoured in RUN)
//   coef_valid/coef_data - coefficient words h[0]..h[NTAPS-1] (signed, C_W)
//   coef_ready           - coefficient word accepted this cycle
//   m_valid/m_data/m_sat - output sample (signed, Y_W) and clip flag
//   m_ready              - downstream accepts the output
//
// state | meaning
// ------+-------------------------------------------------------------
// INIT  | one cycle after reset; no transfers accepted
// RUN   | streaming; samples accepted while not stalled
// DRAIN | reload requested; wait for every pipeline valid to clear
// LOAD  | accept NTAPS coefficient words, then clear history and RUN
module fir_pipe_param
  import fir_pkg::*;
#(
  parameter int X_W       = 8,
  parameter int C_W       = 6,
  parameter int NTAPS     = 10,
  parameter int Y_W       = 14,
  parameter int OUT_SHIFT = 0,
  parameter int ACC_W     = X_W + C_W + clog2(NTAPS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic signed [X_W-1:0] s_data,
  output logic                  s_ready,
  input  logic                  coef_start,
  input  logic                  coef_valid,
  input  logic signed [C_W-1:0] coef_data,
  output logic                  coef_ready,
  output logic                  m_valid,
  output logic signed [Y_W-1:0] m_data,
  output logic                  m_sat,
  input  logic                  m_ready
);

  localparam int P_W   = X_W + C_W;
  localparam int CNT_W = (clog2(NTAPS) > 0) ? clog2(NTAPS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NTAPS - 1);

  fir_state_t state, state_nxt;

  logic [CNT_W-1:0]        cnt;
  logic signed [C_W-1:0]   h    [NTAPS];
  logic signed [X_W-1:0]   dl   [NTAPS-1];
  logic signed [X_W-1:0]   win  [NTAPS];
  logic signed [P_W-1:0]   prod [NTAPS];
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] acc;
  logic                    v1, v2;
  logic                    stall;
  logic                    s_accept;
  logic                    coef_wr;
  logic                    load_done;
  logic                    pipe_empty;

  assign stall      = m_valid && !m_ready;
  assign s_accept   = s_valid && s_ready;
  assign coef_wr    = coef_valid && coef_ready;
  assign load_done  = coef_wr && (cnt == LAST_IDX);
  assign pipe_empty = !v1 && !v2 && !m_valid;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    coef_ready = 1'b0;
    case (state)
      ST_INIT:  state_nxt = ST_RUN;
      ST_RUN: begin
        s_ready = !stall;
        // A sample offered alongside coef_start is still taken.
        if (coef_start) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (pipe_empty) state_nxt = ST_LOAD;
      ST_LOAD: begin
        coef_ready = 1'b1;
        if (load_done) state_nxt = ST_RUN;
      end
      default:  state_nxt = ST_INIT;
    endcase
  end

  // Coefficient bank and write pointer; cnt sits at 0 outside LOAD so each
  // LOAD starts from h[0].
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      for (int k = 0; k < NTAPS; k++) h[k] <= '0;
    end else if (state != ST_LOAD) begin
      cnt <= '0;
    end else if (coef_wr) begin
      for (int k = 0; k < NTAPS; k++)
        if (cnt == CNT_W'(k)) h[k] <= coef_data;
      cnt <= load_done ? '0 : cnt + CNT_W'(1);
    end
  end

  // Delay line x[n-1]..x[n-NTAPS+1]; new coefficients start from zero history.
  always_ff @(posedge clk) begin
    if (reset || load_done) begin
      for (int k = 0; k < NTAPS - 1; k++) dl[k] <= '0;
    end else if (s_accept) begin
      dl[0] <= s_data;
      for (int k = 1; k < NTAPS - 1; k++) dl[k] <= dl[k-1];
    end
  end

  always_comb begin
    win[0] = s_data;
    for (int k = 1; k < NTAPS; k++) win[k] = dl[k-1];
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < NTAPS; k++) sum = sum + ACC_W'(prod[k]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      acc <= '0;
      for (int k = 0; k < NTAPS; k++) prod[k] <= '0;
    end else if (!stall) begin
      v1 <= s_accept;
      for (int k = 0; k < NTAPS; k++)
        prod[k] <= P_W'(h[k]) * P_W'(win[k]);
      v2  <= v1;
      acc <= sum;
    end
  end

  fir_sat_stage #(
    .ACC_W    (ACC_W),
    .Y_W      (Y_W),
    .OUT_SHIFT(OUT_SHIFT)
  ) u_sat (
    .clk     (clk),
    .reset   (reset),
    .en      (!stall),
    .in_valid(v2),
    .acc     (acc),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_sat   (m_sat)
  );

endmodule
